// File: rtl/rids_packer.sv
// rids_packer
//
// Bit-serial packer that turns one header field's rule-match bitmap into a
// sorted, fixed-size RIDS word for the bitonic merge tree. The bitmap is
// scanned one bit per cycle from rule 0 upwards. Every set bit is appended
// to the next free slot, so slots come out strictly ascending with NULL
// (all-ones) padding after the last valid ID. Only the lowest NUM_RID matches
// are kept.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   in_valid     in_bitmap is valid
//   in_ready     block can accept a bitmap (high only in IDLE)
//   in_bitmap    bit i = 1 means rule i matched ([0:NUM_RULES-1])
//   out_valid    out_rids / out_count (/ out_overflow) are valid
//   out_ready    downstream accepts the output
//   out_rids     slot k at bits [k*RID_WIDTH +: RID_WIDTH], slot 0 leftmost
//   out_count    number of non-NULL slots, 0..NUM_RID
//   out_overflow more than NUM_RID bits were set (only with RIDS_OVERFLOW_EN)
//
// Build option:
//   RIDS_OVERFLOW_EN  when defined, adds the out_overflow port and its
//                     register. When undefined, excess IDs are dropped
//                     silently.

module rids_packer #(
  parameter int unsigned NUM_RID     = 8,
  parameter int unsigned log_NUM_RID = 3,
  parameter int unsigned RID_WIDTH   = 4,
  parameter int unsigned NUM_RULES   = 2**RID_WIDTH - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:NUM_RULES-1]         in_bitmap,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:NUM_RID*RID_WIDTH-1] out_rids,
  output logic [log_NUM_RID:0]         out_count
`ifdef RIDS_OVERFLOW_EN
  ,
  output logic                         out_overflow
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  // Last bitmap position and the saturation value of the slot counter.
  localparam logic [RID_WIDTH-1:0]   LAST_IDX = RID_WIDTH'(NUM_RULES - 1);
  localparam logic [log_NUM_RID:0]   FULL_CNT = (log_NUM_RID + 1)'(NUM_RID);

  state_t                         state_q;
  logic [0:NUM_RULES-1]           bitmap_q;
  logic [RID_WIDTH-1:0]           idx_q;
  logic [log_NUM_RID:0]           count_q;
  logic [0:NUM_RID*RID_WIDTH-1]   rids_q;
  logic                           valid_q;
`ifdef RIDS_OVERFLOW_EN
  logic                           overflow_q;
`endif

  logic                           cur_bit;
  logic                           slots_full;
  logic [log_NUM_RID-1:0]         slot_sel;

  assign cur_bit    = bitmap_q[idx_q];
  assign slots_full = (count_q == FULL_CNT);
  // Only used while count_q < NUM_RID, so the low bits address the slot.
  assign slot_sel   = count_q[log_NUM_RID-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitmap_q   <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      rids_q     <= '1;
      valid_q    <= 1'b0;
`ifdef RIDS_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bitmap_q   <= in_bitmap;
            rids_q     <= '1;
            count_q    <= '0;
            idx_q      <= '0;
`ifdef RIDS_OVERFLOW_EN
            overflow_q <= 1'b0;
`endif
            state_q    <= SCAN;
          end
        end

        SCAN: begin
          if (cur_bit) begin
            if (!slots_full) begin
              rids_q[slot_sel*RID_WIDTH +: RID_WIDTH] <= idx_q;
              count_q <= count_q + 1'b1;
            end
`ifdef RIDS_OVERFLOW_EN
            else begin
              overflow_q <= 1'b1;
            end
`endif
          end
          // The last bit is processed in the same cycle the scan ends,
          // so idx never wraps.
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        DONE: begin
          // in_valid is not looked at here. A new bitmap is taken in the
          // following IDLE cycle at the earliest.
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = valid_q;
  assign out_rids     = rids_q;
  assign out_count    = count_q;
`ifdef RIDS_OVERFLOW_EN
  assign out_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_rids_packer.sv
// Directed bench for rids_packer (default parameters). The overflow checks
// are compiled in only when RIDS_OVERFLOW_EN is defined.

module tb_rids_packer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:14] in_bitmap;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_rids;
  logic [3:0]  out_count;
`ifdef RIDS_OVERFLOW_EN
  logic        out_overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rids_packer #(
    .NUM_RID     (8),
    .log_NUM_RID (3),
    .RID_WIDTH   (4),
    .NUM_RULES   (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bitmap    (in_bitmap),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rids     (out_rids),
    .out_count    (out_count)
`ifdef RIDS_OVERFLOW_EN
    ,
    .out_overflow (out_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus bitmaps; leftmost literal bit is rule 0.
  localparam logic [0:14] BM_149   = 15'b010010000100000;
  localparam logic [0:14] BM_ZERO  = 15'b000000000000000;
  localparam logic [0:14] BM_ONES  = 15'b111111111111111;
  localparam logic [0:14] BM_7_14  = 15'b000000011111111;
  localparam logic [0:14] BM_14    = 15'b000000000000001;

  // Drive a bitmap at the negedge so it is accepted on the next posedge.
  task automatic accept(input logic [0:14] b);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    in_bitmap = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count posedges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bitmap = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_rids !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_rids: got %h required ffffffff", out_rids); end
    n_checks++;
    if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", out_count); end
`ifdef RIDS_OVERFLOW_EN
    n_checks++;
    if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b required 0", out_overflow); end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    accept(BM_149);
    wait_valid(lat);
    // Accept at edge T, out_valid after edge T+NUM_RULES.
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL basic_latency: got %0d edges required 15", lat); end
    n_checks++;
    if (out_rids !== 32'h149FFFFF) begin n_fail++; $display("FAIL basic_rids: got %h required 149fffff", out_rids); end
    n_checks++;
    if (out_count !== 4'd3) begin n_fail++; $display("FAIL basic_count: got %0d required 3", out_count); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_done: got %b required 0", in_ready); end
`ifdef RIDS_OVERFLOW_EN
    n_checks++;
    if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b required 0", out_overflow); end
`endif
    handshake();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_after_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero();
    int lat;
    accept(BM_ZERO);
    wait_valid(lat);
    n_checks++;
    if (lat !== 15) begin n_fail++; $display("FAIL zero_latency: got %0d required 15", lat); end
    n_checks++;
    if (out_rids !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL zero_rids: got %h required ffffffff", out_rids); end
    n_checks++;
    if (out_count !== 4'd0) begin n_fail++; $display("FAIL zero_count: got %0d required 0", out_count); end
    handshake();
  endtask

  task automatic test_all_ones();
    int lat;
    accept(BM_ONES);
    wait_valid(lat);
    n_checks++;
    if (out_rids !== 32'h01234567) begin n_fail++; $display("FAIL ones_rids: got %h required 01234567", out_rids); end
    n_checks++;
    if (out_count !== 4'd8) begin n_fail++; $display("FAIL ones_count: got %0d required 8", out_count); end
`ifdef RIDS_OVERFLOW_EN
    n_checks++;
    if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ones_overflow: got %b required 1", out_overflow); end
`endif
    handshake();
  endtask

  // Exactly NUM_RID matches: fills every slot without overflowing. Run
  // after test_all_ones so a stale overflow flag would show.
  task automatic test_upper_full();
    int lat;
    accept(BM_7_14);
    wait_valid(lat);
    n_checks++;
    if (out_rids !== 32'h789ABCDE) begin n_fail++; $display("FAIL upper_rids: got %h required 789abcde", out_rids); end
    n_checks++;
    if (out_count !== 4'd8) begin n_fail++; $display("FAIL upper_count: got %0d required 8", out_count); end
`ifdef RIDS_OVERFLOW_EN
    n_checks++;
    if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL upper_overflow: got %b required 0", out_overflow); end
`endif
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    accept(BM_149);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_bitmap = BM_ONES;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rids !== 32'h149FFFFF || out_count !== 4'd3) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b rids=%h count=%0d required 1/0/149fffff/3",
                 c, out_valid, in_ready, out_rids, out_count);
      end
    end
    // in_valid stays high across the output handshake.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (out_rids !== 32'h149FFFFF) begin n_fail++; $display("FAIL bp_rids_kept: got %h required 149fffff", out_rids); end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_rids !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL bp_next_accept: in_ready=%b rids=%h required 0/ffffffff", in_ready, out_rids);
    end
    wait_valid(lat);
    n_checks++;
    if (lat !== 15 || out_rids !== 32'h01234567) begin
      n_fail++;
      $display("FAIL bp_next_result: lat=%0d rids=%h required 15/01234567", lat, out_rids);
    end
    handshake();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    accept(BM_ONES);
    // Seven more edges: the scan now sits at idx 7 with 7 slots filled.
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ctrl: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (out_rids !== 32'hFFFFFFFF || out_count !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_data: rids=%h count=%0d required ffffffff/0", out_rids, out_count);
    end
    @(negedge clk);
    reset = 1'b0;
    accept(BM_14);
    wait_valid(lat);
    n_checks++;
    if (lat !== 15 || out_rids !== 32'hEFFFFFFF || out_count !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_fresh: lat=%0d rids=%h count=%0d required 15/efffffff/1", lat, out_rids, out_count);
    end
    handshake();
  endtask

  // in_valid and out_ready held high: accepts repeat every NUM_RULES+2 cycles.
  task automatic test_back_to_back();
    int first;
    int second;
    bit drained;
    first   = -1;
    second  = -1;
    drained = 1'b0;
    @(negedge clk);
    in_bitmap = BM_149;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (in_ready === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (first < 0 || second < 0 || (second - first) !== 17) begin
      n_fail++;
      $display("FAIL b2b_period: first=%0d second=%0d required spacing 17", first, second);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        drained = 1'b1;
        break;
      end
    end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: in_ready never returned, required 1"); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_all_ones();
    test_upper_full();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
